// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU control codes, funct fields, alu_op values and MDU state.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic {ST_IDLE, ST_BUSY} mdu_state_e;

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: one product or quotient bit per cycle, sign fixup at the end.
module mdu_core
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done_c,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d, opd_q, opd_d;
  logic             is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic             div_zero_q, div_zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] sum, diff;
  logic [WIDTH:0]   rem_sh;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = is_signed & op_a[WIDTH-1];
  assign b_neg = is_signed & op_b[WIDTH-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign busy  = (state_q == ST_BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      sh_q       <= '0;
      opd_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      sh_q       <= sh_d;
      opd_q      <= opd_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      div_zero_q <= div_zero_d;
    end
  end

  // sh holds the multiplier / dividend magnitude, opd the multiplicand / divisor magnitude
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    sh_d       = sh_q;
    opd_d      = opd_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    done_c     = 1'b0;
    res_hi_c   = '0;
    res_lo_c   = '0;
    sum        = '0;
    diff       = '0;
    rem_sh     = '0;
    prod       = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_BUSY;
          count_d    = '0;
          acc_d      = '0;
          sh_d       = a_mag;
          opd_d      = b_mag;
          is_div_d   = is_div;
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = is_div ? a_neg : (a_neg ^ b_neg);
          div_zero_d = is_div & (op_b == '0);
        end
      end
      ST_BUSY: begin
        if (is_div_q) begin
          rem_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
          diff   = {1'b0, rem_sh} - {2'b00, opd_q};
          if (!diff[WIDTH+1]) begin
            acc_d = diff[WIDTH:0];
            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = rem_sh;
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          sum   = {1'b0, acc_q} + (sh_q[0] ? {2'b00, opd_q} : '0);
          acc_d = sum[WIDTH+1:1];
          sh_d  = {sum[0], sh_q[WIDTH-1:1]};
        end
        count_d = CW'(count_q + 1'b1);
        if (count_q == LAST) begin
          state_d = ST_IDLE;
          done_c  = 1'b1;
          if (is_div_q) begin
            res_lo_c = div_zero_q ? '1 : (neg_lo_q ? -sh_d : sh_d);
            res_hi_c = neg_hi_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
          end else begin
            prod = {acc_d[WIDTH-1:0], sh_d};
            if (neg_lo_q) prod = -prod;
            res_hi_c = prod[2*WIDTH-1:WIDTH];
            res_lo_c = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode plus HI/LO registers and stall generation around the iterative MDU.
module alu_ctrl_mdu
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_control,
  output logic             stall,
  output logic             hilo_rd,
  output logic [WIDTH-1:0] hilo_data
);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             hold_q, hold_d;
  logic             busy, done_c, rtype_idle, is_md, is_div, start_c;
  logic [WIDTH-1:0] res_hi_c, res_lo_c;

  always_comb begin
    alu_control = ALU_NOP;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD, F_ADDU: alu_control = ALU_ADD;
          F_SUB, F_SUBU: alu_control = ALU_SUB;
          F_AND:         alu_control = ALU_AND;
          F_OR:          alu_control = ALU_OR;
          F_NOR:         alu_control = ALU_NOR;
          F_SLT:         alu_control = ALU_SLT;
          default:       alu_control = ALU_NOP;
        endcase
      end
      default: alu_control = ALU_NOP;
    endcase
  end

  // hold_q masks the still-held start instruction in the cycle the stall drops
  assign rtype_idle = valid & (alu_op == ALUOP_FUNCT) & !busy;
  assign is_md      = (funct == F_MULT) | (funct == F_MULTU) | (funct == F_DIV) | (funct == F_DIVU);
  assign is_div     = (funct == F_DIV) | (funct == F_DIVU);
  assign start_c    = rtype_idle & is_md & !hold_q;
  assign stall      = start_c | busy;
  assign hilo_rd    = rtype_idle & ((funct == F_MFHI) | (funct == F_MFLO));
  assign hilo_data  = (rtype_idle && funct == F_MFHI) ? hi_q : lo_q;

  mdu_core #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_c),
    .is_div    (is_div),
    .is_signed (!funct[0]),
    .op_a      (rs_val),
    .op_b      (rt_val),
    .busy      (busy),
    .done_c    (done_c),
    .res_hi_c  (res_hi_c),
    .res_lo_c  (res_lo_c)
  );

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hold_d = done_c;
    if (done_c) begin
      hi_d = res_hi_c;
      lo_d = res_lo_c;
    end else if (rtype_idle) begin
      if (funct == F_MTHI) hi_d = rs_val;
      if (funct == F_MTLO) lo_d = rs_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      hold_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed and randomized checks of alu_ctrl_mdu against an arithmetic reference model.
module tb_alu_ctrl_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  alu_control;
  logic        stall, hilo_rd;
  logic [31:0] hilo_data;

  int n_checks = 0;
  int n_err    = 0;

  logic [5:0] dec_f [9] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                            6'b100101, 6'b100111, 6'b101010, 6'b001000};
  logic [3:0] dec_c [9] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                            4'b0001, 4'b1100, 4'b0111, 4'b1111};
  logic [5:0] md_f  [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

  alu_ctrl_mdu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .alu_op      (alu_op),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_control (alu_control),
    .stall       (stall),
    .hilo_rd     (hilo_rd),
    .hilo_data   (hilo_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      6'b011000: return 64'(sa * sb);
      6'b011001: return ua * ub;
      6'b011010: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {(ua % ub) , 32'h0} | {32'h0, 32'(ua / ub)};
      end
    endcase
  endfunction

  // Issue a mult/div, count stall cycles, then read back HI and LO with MFHI/MFLO
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int cyc);
    valid = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
    cyc = 0;
    #1;
    while (stall && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("no_retrigger", 64'(stall), 64'd0);
    @(posedge clk); #1;
    funct = 6'b010000;
    #1;
    check("mfhi_rd", 64'(hilo_rd), 64'd1);
    hi = hilo_data;
    @(posedge clk); #1;
    funct = 6'b010010;
    #1;
    lo = hilo_data;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  initial begin
    logic [31:0] hi, lo, a, b;
    logic [63:0] exp;
    logic [5:0]  f;
    int cyc;

    rst_n = 1'b0; valid = 1'b0; alu_op = 2'b00; funct = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hilo_rd", 64'(hilo_rd), 64'd0);
    check("rst_hilo_data", 64'(hilo_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    alu_op = 2'b00; #1; check("dec_op00", 64'(alu_control), 64'h2);
    alu_op = 2'b01; #1; check("dec_op01", 64'(alu_control), 64'h6);
    alu_op = 2'b11; #1; check("dec_op11", 64'(alu_control), 64'hF);
    alu_op = 2'b10;
    for (int i = 0; i < 9; i++) begin
      funct = dec_f[i];
      #1;
      check($sformatf("dec_funct_%b", dec_f[i]), 64'(alu_control), 64'(dec_c[i]));
    end

    run_md(6'b011000, 32'hFFFF_FFFD, 32'd7, hi, lo, cyc);
    check("mult_stall_cycles", 64'(cyc), 64'd33);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo_next", 64'(lo), 64'hFFFF_FFEB);
    run_md(6'b011001, 32'hFFFF_FFFD, 32'd7, hi, lo, cyc);
    check("multu_hi", 64'(hi), 64'h6);
    check("multu_lo", 64'(lo), 64'hFFFF_FFEB);
    run_md(6'b011010, 32'hFFFF_FFF9, 32'd2, hi, lo, cyc);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    run_md(6'b011011, 32'd100, 32'd7, hi, lo, cyc);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_hi", 64'(hi), 64'd2);
    run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, cyc);
    check("div_ovf_lo", 64'(lo), 64'h8000_0000);
    check("div_ovf_hi", 64'(hi), 64'h0);
    run_md(6'b011011, 32'h1234, 32'h0, hi, lo, cyc);
    check("divz_stall_cycles", 64'(cyc), 64'd33);
    check("divz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divz_hi", 64'(hi), 64'h1234);

    valid = 1'b1; alu_op = 2'b10; funct = 6'b010001; rs_val = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    funct = 6'b010011; rs_val = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    funct = 6'b010000; #1;
    check("mthi_rd", 64'(hilo_rd), 64'd1);
    check("mthi_data", 64'(hilo_data), 64'hA5A5_A5A5);
    funct = 6'b010010; #1;
    check("mtlo_rd", 64'(hilo_rd), 64'd1);
    check("mtlo_data", 64'(hilo_data), 64'h5A5A_5A5A);
    funct = 6'b100000; #1;
    check("nonmf_rd", 64'(hilo_rd), 64'd0);

    // Abort in the 10th BUSY cycle
    funct = 6'b011000; rs_val = 32'd9; rt_val = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    check("busy_stall", 64'(stall), 64'd1);
    rst_n = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_lo", 64'(hilo_data), 64'h0);
    rst_n = 1'b1;
    valid = 1'b1; funct = 6'b010000; #1;
    check("abort_hi", 64'(hilo_data), 64'h0);
    valid = 1'b0;
    @(posedge clk); #1;
    run_md(6'b011000, 32'd3, 32'd4, hi, lo, cyc);
    check("post_abort_lo", 64'(lo), 64'd12);
    check("post_abort_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 24; i++) begin
      f = md_f[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 1000));
        3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      exp = ref_md(f, a, b);
      run_md(f, a, b, hi, lo, cyc);
      check($sformatf("rnd%0d_f%b_cycles", i, f), 64'(cyc), 64'd33);
      check($sformatf("rnd%0d_f%b_a%h_b%h", i, f, a, b), {hi, lo}, exp);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
